// File: rtl/omsp_hmac_pkg.sv
// rtl/omsp_hmac_pkg.sv - shared feeder state encoding, RATE legality and HMAC data_available encodings
package omsp_hmac_pkg;

    typedef enum logic [2:0] {
        FEED_IDLE       = 3'd0,
        FEED_FETCH      = 3'd1,
        FEED_ISSUE      = 3'd2,
        FEED_WAIT       = 3'd3,
        FEED_FINAL      = 3'd4,
        FEED_FINAL_WAIT = 3'd5
    } feed_state_e;

    // data_available qualifier carried with hmac_start_continue
    localparam logic HMAC_DA_DATA  = 1'b1;
    localparam logic HMAC_DA_FINAL = 1'b0;

    // chunk widths the HMAC message port accepts
    localparam int HMAC_RATE_NARROW = 8;
    localparam int HMAC_RATE_WIDE   = 16;

    function automatic bit rate_is_legal(input int rate);
        return (rate == HMAC_RATE_NARROW) || (rate == HMAC_RATE_WIDE);
    endfunction

endpackage

// File: rtl/omsp_hmac_word_buf.sv
// rtl/omsp_hmac_word_buf.sv - one- or two-entry 16-bit word buffer, load on read ack, pop on word consumed
module omsp_hmac_word_buf #(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_load_data,
    input  logic        i_pop,
    output logic        o_head_valid,
    output logic [15:0] o_head_next,
    output logic        o_next_valid
);

    logic [15:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [15:0]      w_data [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic             w_placed;

    // next contents: pop shifts toward the head, then a load fills the first free slot
    always_comb begin
        w_data   = r_data;
        w_valid  = r_valid;
        w_placed = 1'b0;
        if (i_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_data[i]  = r_data[i+1];
                w_valid[i] = r_valid[i+1];
            end
            w_valid[DEPTH-1] = 1'b0;
        end
        if (i_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!w_valid[i] && !w_placed) begin
                    w_data[i]  = i_load_data;
                    w_valid[i] = 1'b1;
                    w_placed   = 1'b1;
                end
            end
        end
    end

    // entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
            r_valid <= w_valid;
            r_data  <= w_data;
        end
    end

    // o_head_next is the word the head will hold next cycle, so a registered chunk can be built from it
    assign o_head_valid = r_valid[0];
    assign o_head_next  = w_data[0];
    assign o_next_valid = (DEPTH > 1) && r_valid[DEPTH-1];

endmodule

// File: rtl/omsp_hmac_msg_feeder.sv
// rtl/omsp_hmac_msg_feeder.sv - streams a memory byte range to the HMAC message port; build macro OMSP_HMAC_FEEDER_PREFETCH_EN
module omsp_hmac_msg_feeder
    import omsp_hmac_pkg::*;
#(
    parameter int RATE       = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_end,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_mem_rd_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_rd_ack,
    input  logic [15:0]           i_mem_rd_data,
    input  logic                  i_hmac_busy,
    output logic                  o_hmac_start_continue,
    output logic                  o_hmac_data_available,
    output logic [RATE-1:0]       o_hmac_data_in
);

`ifdef OMSP_HMAC_FEEDER_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
    localparam bit PREFETCH  = 1'b1;
`else
    localparam int BUF_DEPTH = 1;
    localparam bit PREFETCH  = 1'b0;
`endif

    localparam bit RATE_OK = rate_is_legal(RATE);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(RATE / 8);

    if (!RATE_OK) begin : g_bad_rate
        $error("omsp_hmac_msg_feeder: RATE must be 8 or 16");
    end

    feed_state_e           r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_ptr, r_remaining, w_rem_next;
    logic                  r_word_done, w_issue_done;
    logic                  r_error;
    logic                  r_hmac_sc, r_hmac_da;
    logic [RATE-1:0]       r_hmac_data, w_chunk;
    logic                  w_req, w_load, w_pop, w_range_bad, w_accept;
    logic                  w_head_valid, w_next_valid, w_word_avail;
    logic [15:0]           w_head_next;

    assign w_range_bad  = i_addr_end < i_addr_start;
    assign w_accept     = (r_state == FEED_IDLE) && i_start && !w_range_bad;
    assign w_load       = w_req && i_mem_rd_ack;
    // after a finished word the next one must already sit behind it; otherwise the head still has bytes
    assign w_word_avail = r_word_done ? w_next_valid : w_head_valid;

    omsp_hmac_word_buf #(.DEPTH(BUF_DEPTH)) u_word_buf (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_data  (i_mem_rd_data),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head_next  (w_head_next),
        .o_next_valid (w_next_valid)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= FEED_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            FEED_IDLE:       if (w_accept) w_next = FEED_FETCH;
            FEED_FETCH: begin
                if (r_remaining == '0)                w_next = FEED_FINAL;
                else if (w_head_valid || i_mem_rd_ack) w_next = FEED_ISSUE;
            end
            FEED_ISSUE:      w_next = FEED_WAIT;
            FEED_WAIT: begin
                if (!i_hmac_busy) begin
                    if (r_remaining == '0) w_next = FEED_FINAL;
                    else if (w_word_avail) w_next = FEED_ISSUE;
                    else                   w_next = FEED_FETCH;
                end
            end
            FEED_FINAL:      w_next = FEED_FINAL_WAIT;
            FEED_FINAL_WAIT: if (!i_hmac_busy) w_next = FEED_IDLE;
            default:         w_next = FEED_IDLE;
        endcase
    end

    // state-decoded outputs and buffer/memory handshakes
    always_comb begin
        o_busy = (r_state != FEED_IDLE);
        o_done = (r_state == FEED_FINAL_WAIT) && !i_hmac_busy;
        w_pop  = (r_state == FEED_WAIT) && !i_hmac_busy && r_word_done;
        w_req  = (r_state == FEED_FETCH) && (r_remaining != '0) && !w_head_valid;
        // read-ahead of the following word while the HMAC digests the last chunk of the current one
        if (PREFETCH && (r_state == FEED_WAIT) && r_word_done && !w_next_valid && (r_remaining != '0))
            w_req = 1'b1;
    end

    assign o_mem_rd_req = w_req;
    assign o_mem_addr   = w_req ? {r_ptr[ADDR_WIDTH-1:1], 1'b0} : '0;
    assign o_error      = r_error;

    // chunk for the upcoming ISSUE cycle, taken from the word the buffer head will hold
    always_comb begin
        w_chunk = w_head_next[RATE-1:0];
        if (RATE == 8 && r_ptr[0]) w_chunk = RATE'(w_head_next >> 8);
    end

    assign w_rem_next   = (r_remaining >= STEP) ? r_remaining - STEP : '0;
    assign w_issue_done = (RATE != 8) || r_ptr[0] || (r_remaining == ADDR_WIDTH'(1));

    // byte pointer, byte count and word-consumed flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_word_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_error <= (r_state == FEED_IDLE) && i_start && w_range_bad;
            if (w_accept) begin
                r_ptr       <= i_addr_start;
                r_remaining <= i_addr_end - i_addr_start;
                r_word_done <= 1'b0;
            end else if (r_state == FEED_ISSUE) begin
                r_ptr       <= r_ptr + STEP;
                r_remaining <= w_rem_next;
                r_word_done <= w_issue_done;
            end
        end
    end

    // HMAC strobes are flops loaded from the next state so they never follow hmac_busy combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hmac_sc   <= 1'b0;
            r_hmac_da   <= 1'b0;
            r_hmac_data <= '0;
        end else begin
            r_hmac_sc   <= (w_next == FEED_ISSUE) || (w_next == FEED_FINAL);
            r_hmac_da   <= (w_next == FEED_ISSUE) ? HMAC_DA_DATA : HMAC_DA_FINAL;
            r_hmac_data <= (w_next == FEED_ISSUE) ? w_chunk : '0;
        end
    end

    assign o_hmac_start_continue = r_hmac_sc;
    assign o_hmac_data_available = r_hmac_da;
    assign o_hmac_data_in        = r_hmac_data;

endmodule

// File: doc/omsp_hmac_msg_feeder.md
# omsp_hmac_msg_feeder

Upstream message feeder for the HMAC engine. On a start pulse it reads a byte range of memory as 16-bit little-endian words and streams it to the HMAC message port in RATE-bit chunks. It then issues the finalization request and signals completion. It sits between the crypto control unit (address range, start) and the HMAC block (start_continue / data_available / data_in / busy).

## Interface
- RATE, default 8: HMAC chunk width in bits; legal values are 8 or 16.
- ADDR_WIDTH, default 16: byte address width.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- start  in  1  one-cycle request; sampled only when busy=0.
- addr_start  in  ADDR_WIDTH  first byte address (inclusive); sampled with start.
- addr_end  in  ADDR_WIDTH  end byte address (exclusive); sampled with start.
- busy  out  1  high from the cycle after an accepted start until the done cycle.
- done  out  1  one-cycle pulse when finalization completes.
- error  out  1  one-cycle pulse when the range is rejected (addr_end < addr_start).
- mem_rd_req  out  1  word read request; held until acked.
- mem_addr  out  ADDR_WIDTH  word-aligned read address; bit 0 is always 0.
- mem_rd_ack  in  1  read complete; mem_rd_data is valid in the same cycle.
- mem_rd_data  in  16  read word; low byte = even address.
- hmac_busy  in  1  HMAC busy; combinational from the HMAC next-state logic.
- hmac_start_continue  out  1  registered, one-cycle pulse.
- hmac_data_available  out  1  registered, qualifies the pulse (1 = data, 0 = finalize).
- hmac_data_in  out  RATE  chunk; valid with the pulse.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, FINAL, FINAL_WAIT.
- IDLE
  - All outputs are 0.
  - On start with addr_end ≥ addr_start: latch ptr=addr_start and remaining=addr_end-addr_start, go to FETCH.
  - On start with addr_end < addr_start: error pulse, stay in IDLE.
- FETCH
  - Hold mem_rd_req=1 with mem_addr={ptr[ADDR_WIDTH-1:1],1'b0} until mem_rd_ack.
  - On ack: load the word buffer, go to ISSUE.
  - If remaining==0 on entry: go to FINAL with no read.
- ISSUE
  - Pulse hmac_start_continue=1 and hmac_data_available=1.
  - RATE=8: chunk = buffer byte ptr[0] (low byte if even, high byte if odd); ptr+=1, remaining-=1.
  - RATE=16: chunk = whole word; ptr+=2, remaining-=2 (saturates at 0).
  - Go to WAIT.
- WAIT
  - Stay while hmac_busy=1.
  - When hmac_busy=0:
    - remaining==0 → FINAL.
    - Otherwise, if the buffer still holds unsent bytes of the current word (RATE=8, ptr odd) → ISSUE.
    - Otherwise → FETCH.
- FINAL: pulse hmac_start_continue=1 with hmac_data_available=0, go to FINAL_WAIT.
- FINAL_WAIT: when hmac_busy=0, pulse done and go to IDLE.
- Odd addr_start: the first word fetched is the containing word; its low byte is skipped.
- Odd end with RATE=8: the high byte of the last word is never sent.
- Odd byte count with RATE=16 is not supported. The last chunk carries the unused high byte, and the caller guarantees an even count.
- Pulses per message = ceil(len·8/RATE) data pulses + 1 finalize pulse.
- start while busy=1 is ignored.

## Timing
- Reset values: busy, done, error, mem_rd_req, hmac_start_continue and hmac_data_available are 0; mem_addr and hmac_data_in are 0.
- A reset mid-operation aborts in one cycle back to IDLE with no done. The HMAC shares the reset.
- start accepted in cycle t → busy=1 and mem_rd_req=1 in t+1.
- mem_rd_ack in cycle a → hmac_start_continue pulse in a+1.
- No hmac output depends combinationally on hmac_busy, so there is no loop through the HMAC next-state logic. hmac_busy is not acted on during the pulse cycle; WAIT starts checking the cycle after.
- Zero-length range: finalize pulse at t+2, then done once hmac_busy falls.

## Configuration
- OMSP_HMAC_FEEDER_PREFETCH_EN
  - Defined: a second word buffer. The read of the next word is issued during WAIT of the current word's last chunk. FETCH is skipped when the prefetched word is already valid, and the mem request is aborted only on reset. No read is issued past addr_end.
  - Undefined: reads are issued only from FETCH, strictly after the HMAC has consumed the previous word. Pulse ordering and values are identical in both builds; only cycle counts differ.

## Structure
- Shared package omsp_hmac_pkg: feeder state encoding (width 3), the RATE legality check constant, and the HMAC data_available encodings, shared with the HMAC block.
- Sub-module omsp_hmac_word_buf: one or two 16-bit entries with valid flags, load on ack, pop on word consumed. The depth is set by the macro.

## Test plan
- Range 0x0200–0x0204 with words 0x2211, 0x4433, RATE=8 → data chunks 0x11, 0x22, 0x33, 0x44, then one finalize pulse, then done; 2 mem reads.
- Range 0x0201–0x0204 → chunks 0x22, 0x33, 0x44; the first mem_addr is 0x0200; the high byte of 0x0202 is included.
- addr_start = addr_end = 0x0300 → no mem_rd_req, only the finalize pulse, then done.
- addr_end=0x0100 < addr_start=0x0200 → error pulse, busy stays 0, no HMAC pulse.
- hmac_busy held high 10 cycles after each pulse; mem_rd_ack delayed 3 cycles → no pulse issued while hmac_busy=1; a chunk is never issued before its ack.
- Reset asserted in WAIT of the 2nd chunk → next cycle all outputs are 0 and the state is IDLE; a subsequent start runs a fresh message correctly.
